// File: rtl/jacobi_iter_ctrl.sv
// Jacobi iteration controller: iterates an external combinational stage until fixpoint or cap, then streams the vector.
// Latency: one cycle per iteration after start, then one element per accepted out_valid/out_ready beat, then a done pulse.
// Backpressure: out_ready low stalls the stream; out_data/out_idx hold until the element is accepted.
module jacobi_iter_ctrl #(
  parameter int WIDTH    = 8,
  parameter int NU       = 10,
  parameter int MAX_ITER = 64,
  parameter int ITER_W   = 16,
  localparam int IDX_W   = (NU > 1) ? $clog2(NU) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH*NU-1:0]   u_init,
  output logic [WIDTH*NU-1:0]   u_cur,
  input  logic [WIDTH*NU-1:0]   u_next,
  output logic                  busy,
  output logic [ITER_W-1:0]     iter_count,
  output logic                  converged,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [IDX_W-1:0]      out_idx,
  output logic                  out_last,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ITER   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state;

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NU - 1);
  localparam logic [ITER_W-1:0] ITER_CAP = ITER_W'(MAX_ITER);

  // View of the packed vector as individual elements for the output mux
  logic [WIDTH-1:0] elem [NU];
  for (genvar k = 0; k < NU; k++) begin : g_elem
    assign elem[k] = u_cur[k*WIDTH +: WIDTH];
  end

  logic [ITER_W-1:0] iter_inc;
  logic              fixpoint;
  logic              xfer;

  assign iter_inc = iter_count + 1'b1;
  assign fixpoint = (u_next == u_cur);
  assign xfer     = out_valid && out_ready;
  assign out_data = elem[out_idx];
  assign out_last = out_valid && (out_idx == LAST_IDX);

  // Control FSM; all status outputs are registered alongside the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      u_cur      <= '0;
      iter_count <= '0;
      converged  <= 1'b0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            u_cur      <= u_init;
            iter_count <= '0;
            converged  <= 1'b0;
            busy       <= 1'b1;
            state      <= ITER;
          end
        end
        ITER: begin
          // A fixpoint wins over the cap: no update is applied in that cycle
          if (fixpoint) begin
            converged <= 1'b1;
            out_valid <= 1'b1;
            out_idx   <= '0;
            state     <= STREAM;
          end else begin
            u_cur      <= u_next;
            iter_count <= iter_inc;
            if (iter_inc == ITER_CAP) begin
              converged <= 1'b0;
              out_valid <= 1'b1;
              out_idx   <= '0;
              state     <= STREAM;
            end
          end
        end
        STREAM: begin
          if (xfer) begin
            if (out_idx == LAST_IDX) begin
              out_idx   <= '0;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              out_idx <= out_idx + 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/jacobi_iter_ctrl.md
JACOBI_ITER_CTRL -- requirements
Module: jacobi_iter_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bits per grid element.
REQ-002 SHALL have parameter NU, default 10, number of grid elements.
REQ-003 SHALL have parameter MAX_ITER, default 64, iteration cap (range 1..2^ITER_W-1).
REQ-004 SHALL have parameter ITER_W, default 16, iteration counter width.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port start  input  1  begin a solve; sampled only in IDLE.
REQ-008 SHALL have port u_init  input  WIDTH*NU  initial packed vector; element k occupies bits [k*WIDTH+WIDTH-1 : k*WIDTH].
REQ-009 SHALL have port u_cur  output  WIDTH*NU  current vector, driven to the external combinational jacobi stage.
REQ-010 SHALL have port u_next  input  WIDTH*NU  jacobi stage result for u_cur; the stage has zero latency, so u_next is valid in the same cycle.
REQ-011 SHALL have port busy  output  1  high in ITER and STREAM.
REQ-012 SHALL have port iter_count  output  ITER_W  number of updates applied in the current or last solve.
REQ-013 SHALL have port converged  output  1  last solve ended with u_next == u_cur.
REQ-014 SHALL have port out_valid  output  1  stream element valid.
REQ-015 SHALL have port out_ready  input  1  downstream accepts the element.
REQ-016 SHALL have port out_data  output  WIDTH  streamed element.
REQ-017 SHALL have port out_idx  output  clog2(NU)  index of out_data.
REQ-018 SHALL have port out_last  output  1  high when out_idx == NU-1 and out_valid is high.
REQ-019 SHALL have port done  output  1  one-cycle pulse after the final element transfers.

Function
REQ-020 SHALL implement FSM states IDLE, ITER, STREAM and DONE.
REQ-021 IDLE: on start=1, SHALL load u_cur <= u_init, set iter_count <= 0, clear converged, and go to ITER next cycle.
REQ-022 ITER: each cycle SHALL compare u_next with u_cur over the full WIDTH*NU bits.
REQ-023 ITER, equal: SHALL set converged <= 1, leave u_cur and iter_count unchanged, and go to STREAM.
REQ-024 ITER, not equal: SHALL set u_cur <= u_next and iter_count <= iter_count+1.
REQ-025 ITER, not equal, if the incremented iter_count == MAX_ITER: SHALL go to STREAM with converged=0.
REQ-026 Equality SHALL take precedence over the cap when both apply in the same cycle.
REQ-027 STREAM: out_valid=1 and out_data = element out_idx of u_cur; out_idx SHALL start at 0 on entry.
REQ-028 STREAM: a transfer SHALL occur only when out_valid && out_ready.
- On a transfer, out_idx increments.
- Without a transfer, out_data and out_idx SHALL hold stable.
REQ-029 STREAM: a transfer with out_last=1 SHALL move the FSM to DONE, with out_idx returning to 0.
REQ-030 DONE: done=1 for exactly one cycle, then IDLE; out_valid=0 in DONE.
REQ-031 start SHALL be ignored in ITER, STREAM and DONE.
REQ-032 iter_count and converged SHALL hold their values in IDLE until the next accepted start.
REQ-033 u_cur SHALL remain constant in STREAM, DONE and IDLE.

Reset
REQ-034 Asserting rst SHALL immediately force the following values, regardless of clk:
- state=IDLE
- u_cur=0, iter_count=0, converged=0
- out_valid=0, out_idx=0, out_last=0, done=0, busy=0
REQ-035 rst asserted mid-ITER or mid-STREAM SHALL abort the solve with no further out_valid or done.
REQ-036 After rst deasserts, the first rising edge with start=1 SHALL begin a solve normally.

Verification
REQ-037 Identity stub (u_next=u_cur), u_init elements 0..9, start -> converged=1, iter_count=0, stream 0,1,...,9, out_last on idx 9, done pulse.
REQ-038 Increment stub (each element +1), MAX_ITER=4, u_init all 0 -> converged=0, iter_count=4, stream ten values of 4.
REQ-039 Real jacobi stage, u_init all 0 -> converges with iter_count=0 and streams ten zeros.
REQ-040 out_ready pattern 1,0,0,1,... during STREAM -> each element presented stable until accepted, no element lost or duplicated, done one cycle after idx 9 transfer.
REQ-041 rst pulse asserted during ITER cycle 2 -> all outputs at reset values immediately; a new start afterwards completes normally.
REQ-042 start pulsed during STREAM -> ignored; u_cur, iter_count and the element sequence are unchanged.
